// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller
//   Main control FSM of a multicycle MIPS core. It shares one instruction/data
//   memory across states. It also keeps a retired-instruction counter and a
//   sticky illegal-instruction trap flag.
//
// Handshake: memread/memwrite are requests that stay asserted, with a
//   constant iord, until mem_ready is sampled high at a rising clock edge.
//   mem_ready has no effect outside the memory states (FETCH, MEMRD, MEMWR).
//   With MEM_WAIT_EN = 0, mem_ready is ignored and taken as 1.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   op, funct         instruction fields from the instruction register
//   zero              ALU zero flag, used for beq
//   mem_ready         memory completes the current access this cycle
//   iord .. ULAcontrol datapath control (Moore, gated by mem_ready / zero)
//   illegal           sticky trap flag
//   instr_count       retired instructions, wraps modulo 2^CNT_W
//   state             current FSM state encoding (debug)
module mips_multicycle_controller #(
  parameter int MEM_WAIT_EN = 1,
  parameter int CNT_W       = 32,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               ULAsrcA,
  output logic [1:0]         ULAsrcB,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic [2:0]         ULAcontrol,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             ready_eff;

  assign ready_eff = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  always_comb begin
    state_d    = state_q;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    ULAsrcA    = 1'b0;
    ULAsrcB    = 2'b00;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    ULAcontrol = 3'b000;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread    = 1'b1;
        ULAsrcB    = 2'b01;
        ULAcontrol = ALU_ADD;
        // IR load and PC+4 happen only on the edge that completes the read.
        irwrite    = ready_eff;
        pcen       = ready_eff;
        if (ready_eff) state_d = S_DECODE;
      end
      S_DECODE: begin
        ULAsrcB    = 2'b11;
        ULAcontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ULAsrcA    = 1'b1;
        ULAsrcB    = 2'b10;
        ULAcontrol = ALU_ADD;
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_TRAP;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (ready_eff) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (ready_eff) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        ULAsrcA = 1'b1;
        state_d = S_ALUWB;
        case (funct)
          6'b100000: ULAcontrol = ALU_ADD;
          6'b100010: ULAcontrol = ALU_SUB;
          6'b100100: ULAcontrol = ALU_AND;
          6'b100101: ULAcontrol = ALU_OR;
          6'b101010: ULAcontrol = ALU_SLT;
          default:   state_d    = S_TRAP;
        endcase
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ULAsrcA    = 1'b1;
        ULAcontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        ULAsrcA    = 1'b1;
        ULAsrcB    = 2'b10;
        ULAcontrol = ALU_ADD;
        state_d    = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // The trap flag is set on the edge that enters TRAP and held until reset.
  assign illegal_d = illegal_q | (state_d == S_TRAP);
  assign cnt_d     = retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign illegal     = illegal_q;
  assign instr_count = cnt_q;
  assign state       = STATE_W'(state_q);

endmodule
